// File: rtl/fetch_queue_ctrl.sv
// fetch_queue_ctrl: credit-based in-order fetch sequencer feeding the instruction FIFO, with redirect flush/drain
module fetch_queue_ctrl #(
  parameter int AddrWidth = 64,
  parameter int InstWidth = 32,
  parameter int FifoDepth = 4,
  parameter int MaxOutstanding = 2,
  parameter logic [AddrWidth-1:0] ResetPc = AddrWidth'(64'h8000_0000)
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           Jump,
  input  logic [AddrWidth-1:0]           JumpPc,
  output logic                           ReqValid,
  input  logic                           ReqReady,
  output logic [AddrWidth-1:0]           ReqAddr,
  input  logic                           RespValid,
  input  logic [InstWidth-1:0]           RespData,
  input  logic                           DecRInc,
  output logic [AddrWidth+InstWidth-1:0] FifoWData,
  output logic                           FifoWInc,
  output logic                           FifoRInc,
  output logic                           FifoJump,
  output logic [$clog2(FifoDepth+1)-1:0] Count
);
  localparam int CW = $clog2(FifoDepth+1);
  localparam int OW = $clog2(MaxOutstanding+1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;
  state_e state_q, state_d;
  logic [AddrWidth-1:0] req_pc_q, req_pc_d, resp_pc_q, resp_pc_d, jump_pc;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d, drop_jump;
  logic jmp, resp_live, wr, rd, req_valid, issue;
  always_comb begin
    jmp = Jump & Rst;
    jump_pc = JumpPc & ~AddrWidth'(3);
    // a response with nothing issued or awaiting drop is a protocol error and is ignored
    resp_live = RespValid & ((outstanding_q != '0) | (drop_cnt_q != '0));
    wr = Rst & ~Jump & RespValid & (state_q == FETCH) & (outstanding_q != '0);
    rd = Rst & ~Jump & DecRInc & (count_q != '0);
    req_valid = Rst & ~Jump & (state_q == FETCH)
              & (32'(count_q) + 32'(outstanding_q) < 32'(FifoDepth))
              & (32'(outstanding_q) < 32'(MaxOutstanding));
    issue = req_valid & ReqReady;
    drop_jump = drop_cnt_q + outstanding_q - OW'(resp_live);
    req_pc_d = jmp ? jump_pc : issue ? req_pc_q + AddrWidth'(4) : req_pc_q;
    resp_pc_d = jmp ? jump_pc : wr ? resp_pc_q + AddrWidth'(4) : resp_pc_q;
    count_d = jmp ? '0 : count_q + CW'(wr) - CW'(rd);
    outstanding_d = jmp ? '0 : outstanding_q + OW'(issue) - OW'(wr);
    drop_cnt_d = jmp ? drop_jump
               : (state_q == DRAIN && RespValid && drop_cnt_q != '0) ? drop_cnt_q - OW'(1)
               : drop_cnt_q;
    state_d = jmp ? (drop_jump != '0 ? DRAIN : FETCH)
            : state_q == IDLE ? FETCH
            : (state_q == DRAIN && (drop_cnt_q == '0 || (drop_cnt_q == OW'(1) && RespValid))) ? FETCH
            : state_q;
  end
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= IDLE;
      req_pc_q <= ResetPc;
      resp_pc_q <= ResetPc;
      count_q <= '0;
      outstanding_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      req_pc_q <= req_pc_d;
      resp_pc_q <= resp_pc_d;
      count_q <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign ReqValid = req_valid;
  assign ReqAddr = req_pc_q;
  assign FifoWData = {resp_pc_q, RespData};
  assign FifoWInc = wr;
  assign FifoRInc = rd;
  assign FifoJump = jmp;
  assign Count = count_q;
  a_limits: assert property (@(posedge Clk) disable iff (!Rst)
    count_q <= CW'(FifoDepth) && outstanding_q <= OW'(MaxOutstanding) && drop_cnt_q <= OW'(MaxOutstanding));
endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// tb_fetch_queue_ctrl: table-driven directed vectors plus hand-written redirect/stall/reset sequences
module tb_fetch_queue_ctrl;
  logic Clk = 1'b0, Rst, Jump, ReqValid, ReqReady, RespValid, DecRInc, FifoWInc, FifoRInc, FifoJump;
  logic [63:0] JumpPc, ReqAddr;
  logic [31:0] RespData;
  logic [95:0] FifoWData;
  logic [2:0] Count;
  int errors = 0, checks = 0;
  localparam logic [63:0] B = 64'h8000_0000;

  fetch_queue_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Jump(Jump), .JumpPc(JumpPc), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqAddr(ReqAddr), .RespValid(RespValid), .RespData(RespData), .DecRInc(DecRInc),
    .FifoWData(FifoWData), .FifoWInc(FifoWInc), .FifoRInc(FifoRInc), .FifoJump(FifoJump), .Count(Count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic rst_n, jump;
    logic [63:0] jpc;
    logic ready, rv;
    logic [31:0] rd;
    logic dec, chk, e_rv;
    logic [63:0] e_addr;
    logic e_wi;
    logic [63:0] e_wpc;
    logic e_ri, e_fj;
    logic [2:0] e_cnt;
  } vec_t;

  function automatic vec_t r(input logic rst_n, jump, input logic [63:0] jpc, input logic ready, rv,
                             input logic [31:0] rd, input logic dec, chk, e_rv, input logic [63:0] e_addr,
                             input logic e_wi, input logic [63:0] e_wpc, input logic e_ri, e_fj,
                             input logic [2:0] e_cnt);
    r = '{rst_n, jump, jpc, ready, rv, rd, dec, chk, e_rv, e_addr, e_wi, e_wpc, e_ri, e_fj, e_cnt};
  endfunction

  task automatic cmp(input string nm, input int idx, input logic [63:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    Rst = v.rst_n; Jump = v.jump; JumpPc = v.jpc; ReqReady = v.ready;
    RespValid = v.rv; RespData = v.rd; DecRInc = v.dec;
    @(negedge Clk);
    if (v.chk) begin
      cmp("req_valid", idx, 64'(ReqValid), 64'(v.e_rv));
      cmp("req_addr", idx, ReqAddr, v.e_addr);
      cmp("fifo_winc", idx, 64'(FifoWInc), 64'(v.e_wi));
      cmp("fifo_rinc", idx, 64'(FifoRInc), 64'(v.e_ri));
      cmp("fifo_jump", idx, 64'(FifoJump), 64'(v.e_fj));
      cmp("count", idx, 64'(Count), 64'(v.e_cnt));
      if (v.e_wi) begin
        cmp("wdata_pc", idx, FifoWData[95:32], v.e_wpc);
        cmp("wdata_inst", idx, 64'(FifoWData[31:0]), 64'(v.rd));
      end
    end
    @(posedge Clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    Rst = 0; Jump = 0; JumpPc = '0; ReqReady = 0; RespValid = 0; RespData = '0; DecRInc = 0;
    // streaming with one-cycle response latency, then refill with decode stalled
    tbl.push_back(r(0,0,0,0,0,0,0, 0, 0,B,0,0,0,0,0));
    tbl.push_back(r(0,1,64'h4444,1,1,0,1, 1, 0,B,0,0,0,0,0));
    tbl.push_back(r(1,0,0,0,0,0,0, 1, 0,B,0,0,0,0,0));
    tbl.push_back(r(1,0,0,1,0,0,0, 1, 1,B,0,0,0,0,0));
    tbl.push_back(r(1,0,0,1,1,32'hA0,1, 1, 1,B+4,1,B,0,0,0));
    tbl.push_back(r(1,0,0,1,1,32'hA1,1, 1, 1,B+8,1,B+4,1,0,1));
    tbl.push_back(r(1,0,0,1,1,32'hA2,1, 1, 1,B+12,1,B+8,1,0,1));
    tbl.push_back(r(0,0,0,0,0,0,0, 0, 0,B,0,0,0,0,0));
    tbl.push_back(r(1,0,0,0,0,0,0, 1, 0,B,0,0,0,0,0));
    tbl.push_back(r(1,0,0,1,0,0,0, 1, 1,B,0,0,0,0,0));
    tbl.push_back(r(1,0,0,1,1,32'hB0,0, 1, 1,B+4,1,B,0,0,0));
    tbl.push_back(r(1,0,0,1,1,32'hB1,0, 1, 1,B+8,1,B+4,0,0,1));
    tbl.push_back(r(1,0,0,1,1,32'hB2,0, 1, 1,B+12,1,B+8,0,0,2));
    tbl.push_back(r(1,0,0,1,1,32'hB3,0, 1, 0,B+16,1,B+12,0,0,3));
    tbl.push_back(r(1,0,0,1,0,0,1, 1, 0,B+16,0,0,1,0,4));
    tbl.push_back(r(1,0,0,1,0,0,0, 1, 1,B+16,0,0,0,0,3));
    tbl.push_back(r(1,0,0,0,0,0,0, 1, 0,B+20,0,0,0,0,3));
    @(posedge Clk);
    #1;
    foreach (tbl[i]) run(tbl[i], i);
    // redirect with two requests in flight: both late responses must be dropped
    run(r(0,0,0,0,0,0,0, 0, 0,B,0,0,0,0,0), 100);
    run(r(1,0,0,0,0,0,0, 1, 0,B,0,0,0,0,0), 101);
    run(r(1,0,0,1,0,0,0, 1, 1,B,0,0,0,0,0), 102);
    run(r(1,0,0,1,0,0,0, 1, 1,B+4,0,0,0,0,0), 103);
    run(r(1,1,64'h1002,1,0,0,0, 1, 0,B+8,0,0,0,1,0), 104);
    run(r(1,0,0,1,1,32'hDEAD,0, 1, 0,64'h1000,0,0,0,0,0), 105);
    run(r(1,0,0,1,0,0,0, 1, 0,64'h1000,0,0,0,0,0), 106);
    run(r(1,0,0,1,1,32'hBEEF,0, 1, 0,64'h1000,0,0,0,0,0), 107);
    run(r(1,0,0,1,0,0,0, 1, 1,64'h1000,0,0,0,0,0), 108);
    run(r(1,0,0,0,1,32'h55,0, 1, 1,64'h1004,1,64'h1000,0,0,0), 109);
    run(r(1,0,0,1,0,0,0, 1, 1,64'h1004,0,0,0,0,1), 110);
    // redirect colliding with a response and a decode pop, one request outstanding
    run(r(1,1,64'h2000,1,1,32'h77,1, 1, 0,64'h1008,0,0,0,1,1), 111);
    run(r(1,0,0,0,1,32'h88,0, 1, 1,64'h2000,0,0,0,0,0), 112);
    for (int k = 0; k < 4; k++) run(r(1,0,0,0,0,0,0, 1, 1,64'h2000,0,0,0,0,0), 113 + k);
    // reset in the middle of the stall; late responses afterwards are ignored
    run(r(0,0,0,0,0,0,0, 0, 0,B,0,0,0,0,0), 117);
    run(r(1,0,0,0,1,32'h99,0, 1, 0,B,0,0,0,0,0), 118);
    run(r(1,0,0,0,1,32'h9A,1, 1, 1,B,0,0,0,0,0), 119);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
